// File: rtl/div_issue.sv
// Request front-end for an 8-bit sequential divider: queues tagged requests and runs one division at a time.
// Latency: an accepted request is popped one edge later when idle; a divide-by-zero answers on that edge,
//   otherwise START_HOLD+1 cycles of launch, then up to TIMEOUT cycles waiting for the divider.
// Backpressure: req_ready_o drops while the FIFO is full; the response is held stable until rsp_ready_i.
//
// Ports:
//   clock_i, reset_i                  clock and synchronous active-high reset
//   req_valid_i/req_ready_o, req_*_i  request channel {dividend, divisor, tag}
//   rsp_valid_o/rsp_ready_i, rsp_*_o  response channel {quotient, tag, error code}
//   div_a_o, div_b_o, div_start_o     operands and start pulse to the divider
//   div_q_i, div_complete_i           divider result and done flag
//   busy_o                            work in flight or queued
module div_issue #(
  parameter int DEPTH      = 2,
  parameter int TAG_W      = 4,
  parameter int START_HOLD = 2,
  parameter int TIMEOUT    = 20
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_a_i,
  input  logic [7:0]       req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_q_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [1:0]       rsp_err_o,
  output logic [7:0]       div_a_o,
  output logic [7:0]       div_b_o,
  output logic             div_start_o,
  input  logic [7:0]       div_q_i,
  input  logic             div_complete_i,
  output logic             busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, RESP} state_t;

  // ---------------- request FIFO ----------------
  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  req_t          head;

  state_t        state_q;

  assign req_ready_o = (count_q != CNT_FULL);
  assign push        = req_valid_i && req_ready_o;
  // Entries leave the FIFO only while idle; an empty FIFO never bypasses.
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= '{a: req_a_i, b: req_b_i, tag: req_tag_i};
  end

  // ---------------- sequencing FSM ----------------
  logic [HW-1:0]    hold_q;
  logic [TW-1:0]    timer_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_q_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [1:0]       rsp_err_q;
  logic [7:0]       div_a_q, div_b_q;
  logic             div_start_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      timer_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= ERR_OK;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            rsp_tag_q <= head.tag;
            if (head.b == 8'd0) begin
              // Divide-by-zero never reaches the divider.
              rsp_q_q     <= 8'hFF;
              rsp_err_q   <= ERR_DIV0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              div_a_q     <= head.a;
              div_b_q     <= head.b;
              div_start_q <= 1'b1;
              hold_q      <= '0;
              state_q     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (hold_q == HOLD_LAST) begin
            div_start_q <= 1'b0;
            state_q     <= ARM;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ARM: begin
          // One low cycle so the divider sees a clean falling edge before we listen.
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (div_complete_i) begin
            rsp_q_q     <= div_q_i;
            rsp_err_q   <= ERR_OK;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timer_q == TO_LAST) begin
            rsp_q_q     <= 8'd0;
            rsp_err_q   <= ERR_TO;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_q_o     = rsp_q_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;
  assign div_start_o = div_start_q;
  assign busy_o      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue with a behavioural sequential divider model.
// Expected responses are queued when requests are accepted and compared when the DUT hands them off.
// The consumer-side rsp_ready is driven per scenario to exercise response backpressure.
module tb_div_issue;

  localparam int START_HOLD = 2;
  localparam int TIMEOUT    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0, req_b = '0;
  logic [3:0] req_tag = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_q;
  logic [3:0] rsp_tag;
  logic [1:0] rsp_err;
  logic [7:0] div_a, div_b;
  logic       div_start;
  logic [7:0] div_q = '0;
  logic       div_complete = 1'b0;
  logic       busy;

  div_issue #(.DEPTH(2), .TAG_W(4), .START_HOLD(START_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_q_o(rsp_q), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
    .div_a_o(div_a), .div_b_o(div_b), .div_start_o(div_start),
    .div_q_i(div_q), .div_complete_i(div_complete),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] tag;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   hang = 1'b0;
  bit   saw_full = 1'b0;
  int   pulses = 0;
  int   run_len = 0;
  int   last_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: rising start latches operands; result appears 8 cycles later.
  logic       start_prev = 1'b0;
  logic [7:0] ma = '0, mb = 8'd1;
  int         dcnt = 0;
  always @(posedge clk) begin
    start_prev <= div_start;
    if (div_start && !start_prev) begin
      ma <= div_a;
      mb <= div_b;
      dcnt <= 8;
      div_complete <= 1'b0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        div_complete <= 1'b1;
        div_q <= ma / mb;
      end
    end
  end

  // Start-pulse monitor, full-flag monitor and response scoreboard.
  always @(negedge clk) begin
    if (div_start) run_len = run_len + 1;
    else if (run_len != 0) begin
      last_len = run_len;
      pulses = pulses + 1;
      run_len = 0;
    end
    if (!reset && !req_ready) saw_full = 1'b1;
    if (!reset && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got q=%0d tag=%0d err=%0d, required no response", rsp_q, rsp_tag, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rsp_q, rsp_tag, rsp_err} !== e) begin
          miscompares++;
          $display("FAIL rsp: got q=%0d tag=%0d err=%0d, required q=%0d tag=%0d err=%0d",
                   rsp_q, rsp_tag, rsp_err, e.q, e.tag, e.err);
        end
      end
    end
  end

  task automatic push_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag, input bit expect_rsp);
    int waited = 0;
    exp_t e;
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: req_ready=%0b, required 1 within 200 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      if (b == 8'd0)  e = '{q: 8'hFF, tag: tag, err: 2'b01};
      else if (hang)  e = '{q: 8'd0,  tag: tag, err: 2'b10};
      else            e = '{q: a / b, tag: tag, err: 2'b00};
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (exp_q.size() != 0 || rsp_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if ({rsp_valid, req_ready, busy, div_start, rsp_q, rsp_tag, rsp_err, div_a, div_b} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL %s: valid=%0b ready=%0b busy=%0b start=%0b q=%0d tag=%0d err=%0d a=%0d b=%0d, required ready=1 and all else 0",
               name, rsp_valid, req_ready, busy, div_start, rsp_q, rsp_tag, rsp_err, div_a, div_b);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset_values");
  endtask

  task automatic test_basic();
    int p0 = pulses;
    rsp_ready = 1'b1;
    push_req(8'd100, 8'd7, 4'd3, 1'b1);
    wait_drain(100);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pulses - p0 !== 1 || last_len !== START_HOLD) begin
      miscompares++;
      $display("FAIL start_pulse: pulses=%0d len=%0d, required 1 pulse of %0d", pulses - p0, last_len, START_HOLD);
    end
  endtask

  task automatic test_div0();
    int p0 = pulses;
    rsp_ready = 1'b1;
    push_req(8'd5, 8'd0, 4'd9, 1'b1);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL div0_early: rsp_valid=%0b at accept edge, required 0", rsp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, rsp_q, rsp_err} !== {1'b1, 8'hFF, 2'b01}) begin
      miscompares++;
      $display("FAIL div0_latency: valid=%0b q=%0h err=%0d one edge after accept, required valid=1 q=ff err=1",
               rsp_valid, rsp_q, rsp_err);
    end
    wait_drain(50);
    vectors++;
    if (pulses !== p0 || div_start !== 1'b0) begin
      miscompares++;
      $display("FAIL div0_start: pulses=%0d, required %0d", pulses, p0);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    saw_full = 1'b0;
    push_req(8'd40, 8'd4, 4'd0, 1'b1);
    push_req(8'd77, 8'd11, 4'd1, 1'b1);
    push_req(8'd255, 8'd16, 4'd2, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (saw_full !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_full: saw req_ready low=%0b, required 1", saw_full);
    end
    wait_drain(200);
  endtask

  task automatic test_hold();
    exp_t snap, first;
    int   p0, n;
    rsp_ready = 1'b0;
    push_req(8'd50, 8'd5, 4'd5, 1'b1);
    push_req(8'd60, 8'd6, 4'd6, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    first = exp_q[0];
    snap = '{q: rsp_q, tag: rsp_tag, err: rsp_err};
    p0 = pulses;
    vectors++;
    if (!rsp_valid || snap !== first) begin
      miscompares++;
      $display("FAIL hold_first: valid=%0b q=%0d tag=%0d, required valid=1 q=%0d tag=%0d",
               rsp_valid, snap.q, snap.tag, first.q, first.tag);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({rsp_valid, rsp_q, rsp_tag, rsp_err} !== {1'b1, snap} || div_a !== 8'd50 || pulses !== p0) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d valid=%0b q=%0d tag=%0d err=%0d div_a=%0d, required held with div_a=50",
                 i, rsp_valid, rsp_q, rsp_tag, rsp_err, div_a);
      end
    end
    rsp_ready = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_timeout();
    int n = 0, acc;
    rsp_ready = 1'b1;
    hang = 1'b1;
    push_req(8'd30, 8'd3, 4'd7, 1'b1);
    acc = acc_cyc;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    vectors++;
    if (cyc - acc !== 1 + START_HOLD + 1 + TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_latency: %0d edges after accept, required %0d", cyc - acc, 1 + START_HOLD + 1 + TIMEOUT);
    end
    wait_drain(50);
    hang = 1'b0;
    push_req(8'd9, 8'd3, 4'd8, 1'b1);
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    rsp_ready = 1'b1;
    push_req(8'd200, 8'd10, 4'd1, 1'b0);
    push_req(8'd20, 8'd2, 4'd2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || div_start !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_busy: busy=%0b start=%0b, required busy=1 start=0", busy, div_start);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("reset_mid_values");
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_discard: rsp_valid seen %0d cycles, required 0", seen);
    end
    push_req(8'd81, 8'd9, 4'd4, 1'b1);
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
